// File: rtl/exc_ctrl.sv
// Exception / ertn commit controller: latches a WB-stage event, pulses the CSR
// update bus for one cycle, then holds the pipeline flush through a fetch
// redirect handshake and a fixed drain window before accepting the next event.
module exc_ctrl #(
   parameter int unsigned DRAIN_CYC = 2
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        wb_valid,
   input  logic [4:0]  wb_ex_vec,
   input  logic        wb_ertn,
   input  logic [31:0] wb_pc,
   input  logic        has_int,
   input  logic [31:0] ex_entry,
   input  logic [31:0] ertn_entry,
   output logic        wb_ready,
   output logic        wb_cancel,
   output logic [48:0] csr_in_bus,
   output logic        flush,
   output logic        redirect_valid,
   input  logic        redirect_ready,
   output logic [31:0] redirect_pc
);

   localparam int unsigned PC_W    = 32;
   localparam int unsigned ECODE_W = 6;
   localparam int unsigned ESUB_W  = 9;
   localparam int unsigned CNT_W   = 4;

   localparam logic [ECODE_W-1:0] ECODE_INT  = 6'h00;
   localparam logic [ECODE_W-1:0] ECODE_ADEF = 6'h08;
   localparam logic [ECODE_W-1:0] ECODE_INE  = 6'h0D;
   localparam logic [ECODE_W-1:0] ECODE_SYS  = 6'h0B;
   localparam logic [ECODE_W-1:0] ECODE_BRK  = 6'h0C;
   localparam logic [ECODE_W-1:0] ECODE_ALE  = 6'h09;

   // Payload layout seen by the CSR file.
   typedef struct packed {
      logic               ertn_flush;
      logic               wb_ex;
      logic [ECODE_W-1:0] ecode;
      logic [ESUB_W-1:0]  esubcode;
      logic [PC_W-1:0]    pc;
   } csr_bus_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      COMMIT = 2'd1,
      REDIR  = 2'd2,
      DRAIN  = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                ertn_q, ertn_d;
   logic [PC_W-1:0]     rpc_q, rpc_d;
   csr_bus_t            bus_q, bus_d;
   logic                flush_q, flush_d;
   logic                rvalid_q, rvalid_d;

   logic                exc_c;
   logic                trigger_c;
   logic [ECODE_W-1:0]  ecode_c;

   // Event classification: interrupt or any exception flag beats ertn.
   assign exc_c     = has_int | (|wb_ex_vec);
   assign trigger_c = (state_q == IDLE) & wb_valid & (exc_c | wb_ertn);

   assign wb_ready  = (state_q == IDLE);
   assign wb_cancel = trigger_c & exc_c;

   // Fixed-priority exception code selection.
   always_comb begin
      ecode_c = ECODE_INT;
      if (has_int)           ecode_c = ECODE_INT;
      else if (wb_ex_vec[0]) ecode_c = ECODE_ADEF;
      else if (wb_ex_vec[1]) ecode_c = ECODE_INE;
      else if (wb_ex_vec[2]) ecode_c = ECODE_SYS;
      else if (wb_ex_vec[3]) ecode_c = ECODE_BRK;
      else if (wb_ex_vec[4]) ecode_c = ECODE_ALE;
   end

   // Next-state and next-output logic.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      ertn_d   = ertn_q;
      rpc_d    = rpc_q;
      bus_d    = '0;

      unique case (state_q)
         IDLE: begin
            if (trigger_c) begin
               state_d          = COMMIT;
               ertn_d           = ~exc_c;
               bus_d.ertn_flush = ~exc_c;
               bus_d.wb_ex      = exc_c;
               bus_d.ecode      = exc_c ? ecode_c : '0;
               bus_d.esubcode   = '0;
               bus_d.pc         = wb_pc;
            end
         end
         COMMIT: begin
            state_d = REDIR;
            rpc_d   = ertn_q ? ertn_entry : ex_entry;
         end
         REDIR: begin
            if (redirect_ready) begin
               state_d = DRAIN;
               cnt_d   = CNT_W'(DRAIN_CYC - 1);
            end
         end
         DRAIN: begin
            if (cnt_q == '0) state_d = IDLE;
            else             cnt_d   = cnt_q - CNT_W'(1);
         end
         default: state_d = IDLE;
      endcase

      flush_d  = (state_d != IDLE);
      rvalid_d = (state_d == REDIR);
   end

   // State and registered outputs.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         ertn_q   <= 1'b0;
         rpc_q    <= '0;
         bus_q    <= '0;
         flush_q  <= 1'b0;
         rvalid_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         ertn_q   <= ertn_d;
         rpc_q    <= rpc_d;
         bus_q    <= bus_d;
         flush_q  <= flush_d;
         rvalid_q <= rvalid_d;
      end
   end

   assign csr_in_bus     = bus_q;
   assign flush          = flush_q;
   assign redirect_valid = rvalid_q;
   assign redirect_pc    = rpc_q;

endmodule
